// File: rtl/eth_mdio_frame.sv
`default_nettype none
// ============================================================================
// Module  : eth_mdio_frame
// Brief   : IEEE 802.3 clause-22 MDIO frame engine (preamble, header, TA, data)
//           paced by external MDC-edge strobes. Optional NoPre port when the
//           macro ETH_MDIO_NOPRE_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module eth_mdio_frame #(
    parameter int PRE_BITS = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MdcEn,
    input  logic        MdcEn_n,
    input  logic        Start,
    input  logic        Op,
    input  logic [4:0]  PhyAddr,
    input  logic [4:0]  RegAddr,
    input  logic [15:0] WData,
`ifdef ETH_MDIO_NOPRE_EN
    input  logic        NoPre,
`endif
    input  logic        Mdi,
    output logic        Mdo,
    output logic        MdoEn,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] RData
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [5:0] C_PRE_LAST = 6'(PRE_BITS - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        drv_q, drv_d;
    logic        op_q, op_d;
    logic [4:0]  phy_q, phy_d;
    logic [4:0]  reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mdo_q, mdo_d;
    logic        mdoen_q, mdoen_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        w_drv;
    logic        w_smp;
    logic        w_last;
    logic        w_skip_pre;
    logic [13:0] w_hdr;
    state_t      w_next;

`ifdef ETH_MDIO_NOPRE_EN
    logic        nopre_q, nopre_d;
    assign w_skip_pre = Start & NoPre;
`else
    assign w_skip_pre = 1'b0;
`endif

    // MdcEn wins when both strobes coincide; a bit only completes once it has been driven
    assign w_drv = MdcEn_n & ~MdcEn;
    assign w_smp = MdcEn & drv_q;
    assign w_hdr = {2'b01, (op_q ? 2'b10 : 2'b01), phy_q, reg_q};

    always_comb begin
        w_last = 1'b0;
        w_next = state_q;
        case (state_q)
            S_PRE:   begin w_last = (cnt_q == C_PRE_LAST); w_next = S_HDR;  end
            S_HDR:   begin w_last = (cnt_q == 6'd13);      w_next = S_TA;   end
            S_TA:    begin w_last = (cnt_q == 6'd1);       w_next = S_DATA; end
            S_DATA:  begin w_last = (cnt_q == 6'd15);      w_next = S_FIN;  end
            default: begin w_last = 1'b0;                  w_next = state_q; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drv_d   = drv_q;
        op_d    = op_q;
        phy_d   = phy_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        mdo_d   = mdo_q;
        mdoen_d = mdoen_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef ETH_MDIO_NOPRE_EN
        nopre_d = nopre_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d    = Op;
                    phy_d   = PhyAddr;
                    reg_d   = RegAddr;
                    wdata_d = WData;
`ifdef ETH_MDIO_NOPRE_EN
                    nopre_d = NoPre;
`endif
                    busy_d  = 1'b1;
                    cnt_d   = 6'd0;
                    drv_d   = 1'b0;
                    state_d = w_skip_pre ? S_HDR : S_PRE;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                mdo_d   = 1'b0;
                mdoen_d = 1'b0;
                if (op_q) begin
                    rdata_d = shift_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                if (w_drv) begin
                    drv_d = 1'b1;
                    case (state_q)
                        S_PRE:  begin mdo_d = 1'b1; mdoen_d = 1'b1; end
                        S_HDR:  begin mdo_d = w_hdr[4'd13 - cnt_q[3:0]]; mdoen_d = 1'b1; end
                        // read turnaround and data release the pad to the PHY
                        S_TA:   begin mdo_d = ~op_q & (cnt_q == 6'd0); mdoen_d = ~op_q; end
                        S_DATA: begin mdo_d = ~op_q & wdata_q[4'd15 - cnt_q[3:0]]; mdoen_d = ~op_q; end
                        default: begin mdo_d = mdo_q; mdoen_d = mdoen_q; end
                    endcase
                end else if (w_smp) begin
                    drv_d = 1'b0;
                    cnt_d = cnt_q + 6'd1;
                    if (state_q == S_DATA && op_q) begin
                        shift_d = {shift_q[14:0], Mdi};
                    end
                    if (w_last) begin
                        cnt_d   = 6'd0;
                        state_d = w_next;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            drv_q   <= 1'b0;
            op_q    <= 1'b0;
            phy_q   <= 5'd0;
            reg_q   <= 5'd0;
            wdata_q <= 16'h0000;
            shift_q <= 16'h0000;
            rdata_q <= 16'h0000;
            mdo_q   <= 1'b0;
            mdoen_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ETH_MDIO_NOPRE_EN
            nopre_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drv_q   <= drv_d;
            op_q    <= op_d;
            phy_q   <= phy_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            mdo_q   <= mdo_d;
            mdoen_q <= mdoen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ETH_MDIO_NOPRE_EN
            nopre_q <= nopre_d;
`endif
        end
    end

    assign Mdo   = mdo_q;
    assign MdoEn = mdoen_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign RData = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_mdio_frame.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_mdio_frame
// Brief   : Directed self-checking bench for eth_mdio_frame; MDC strobes come
//           from a 4-Clk phase counter (MdcEn_n at phase 0, MdcEn at phase 2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_mdio_frame;

    localparam int PRE = 32;

    logic        Clk = 1'b0;
    logic        Reset, MdcEn, MdcEn_n, Start, Op, Mdi;
    logic [4:0]  PhyAddr, RegAddr;
    logic [15:0] WData;
    logic        Mdo, MdoEn, Busy, Done;
    logic [15:0] RData;
`ifdef ETH_MDIO_NOPRE_EN
    logic        NoPre;
`endif

    eth_mdio_frame #(.PRE_BITS(PRE)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .MdcEn   (MdcEn),
        .MdcEn_n (MdcEn_n),
        .Start   (Start),
        .Op      (Op),
        .PhyAddr (PhyAddr),
        .RegAddr (RegAddr),
        .WData   (WData),
`ifdef ETH_MDIO_NOPRE_EN
        .NoPre   (NoPre),
`endif
        .Mdi     (Mdi),
        .Mdo     (Mdo),
        .MdoEn   (MdoEn),
        .Busy    (Busy),
        .Done    (Done),
        .RData   (RData)
    );

    always #5 Clk = ~Clk;

    int           tests = 0;
    int           fails = 0;
    int           ph = 0;
    int           nbits, cur_dstart, ndone, gap;
    bit           rec = 1'b0, seen_n, cur_read;
    logic [15:0]  cur_rword, rdata_at_done;
    logic         busy_at_done, got_done;
    logic [127:0] got_m, got_en, exp_m, exp_en;
    int           exp_n;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one Clk: drive strobes/Mdi, clock, then record the bit the PHY sees at Mdc rise
    task automatic step();
        int d;
        MdcEn   = (ph == 2);
        MdcEn_n = (ph == 0);
        if (rec && ph == 2 && seen_n && cur_read) begin
            d   = nbits - cur_dstart;
            Mdi = (d >= 0 && d < 16) ? cur_rword[15 - d] : 1'b1;
        end
        @(posedge Clk);
        #1;
        if (rec) begin
            if (ph == 0) seen_n = 1'b1;
            if (ph == 2 && seen_n) begin
                got_m  = {got_m[126:0], Mdo};
                got_en = {got_en[126:0], MdoEn};
                nbits++;
                seen_n = 1'b0;
            end
        end
        ph = (ph + 1) % 4;
    endtask

    function automatic void build(input logic op, input logic [4:0] phy, input logic [4:0] rg,
                                  input logic [15:0] wd, input logic nopre,
                                  output logic [127:0] m, output logic [127:0] en, output int n);
        logic [13:0] hdr;
        m = '0; en = '0; n = 0;
        hdr = {2'b01, (op ? 2'b10 : 2'b01), phy, rg};
        if (!nopre)
            for (int i = 0; i < PRE; i++) begin m = {m[126:0], 1'b1}; en = {en[126:0], 1'b1}; n++; end
        for (int i = 13; i >= 0; i--) begin m = {m[126:0], hdr[i]}; en = {en[126:0], 1'b1}; n++; end
        for (int i = 0; i < 2; i++) begin
            m  = {m[126:0], (!op && i == 0)};
            en = {en[126:0], !op};
            n++;
        end
        for (int i = 15; i >= 0; i--) begin
            m  = {m[126:0], (!op && wd[i])};
            en = {en[126:0], !op};
            n++;
        end
    endfunction

    task automatic run_frame(input logic op, input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] wd, input logic [15:0] rw, input logic nopre,
                             input int inj_bit, input int rst_bit);
        bit injected;
        injected = 1'b0;
        Op = op; PhyAddr = phy; RegAddr = rg; WData = wd;
`ifdef ETH_MDIO_NOPRE_EN
        NoPre = nopre;
`endif
        Start = 1'b1;
        nbits = 0; got_m = '0; got_en = '0; ndone = 0; gap = 0;
        seen_n = 1'b0; got_done = 1'b0;
        cur_read = op; cur_rword = rw;
        cur_dstart = (nopre ? 0 : PRE) + 16;
        step();
        Start = 1'b0;
        Op = ~op; PhyAddr = ~phy; RegAddr = ~rg; WData = ~wd;
        check("busy_after_start", Busy, 1'b1);
        rec = 1'b1;
        for (int c = 0; c < 2000 && !got_done; c++) begin
            if (inj_bit >= 0 && nbits == inj_bit && !injected) begin
                Start = 1'b1;
                injected = 1'b1;
            end
            if (rst_bit >= 0 && nbits == rst_bit) begin
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                rec = 1'b0;
                return;
            end
            step();
            Start = 1'b0;
            if (Done) begin
                got_done = 1'b1;
                ndone++;
                rdata_at_done = RData;
                busy_at_done = Busy;
            end else if (!Busy) begin
                gap++;
            end
        end
        rec = 1'b0;
        check("frame_done_seen", got_done, 1'b1);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 1'b0; PhyAddr = '0; RegAddr = '0;
        WData = '0; Mdi = 1'b1; MdcEn = 1'b0; MdcEn_n = 1'b0;
`ifdef ETH_MDIO_NOPRE_EN
        NoPre = 1'b0;
`endif
        repeat (3) step();
        check("rst_busy",  Busy,  1'b0);
        check("rst_done",  Done,  1'b0);
        check("rst_mdo",   Mdo,   1'b0);
        check("rst_mdoen", MdoEn, 1'b0);
        check("rst_rdata", RData, 16'h0000);
        Reset = 1'b0;
        repeat (2) step();

        // write frame A5C3 to PHY 1 reg 4
        run_frame(1'b0, 5'h01, 5'h04, 16'hA5C3, 16'h0000, 1'b0, -1, -1);
        check("wr_nbits", nbits, 64);
        check("wr_mdo_literal", got_m[63:0], 64'hFFFF_FFFF_5092_A5C3);
        check("wr_mdoen", got_en[63:0], {64{1'b1}});
        check("wr_done_count", ndone, 1);
        check("wr_rdata_unchanged", rdata_at_done, 16'h0000);
        check("wr_busy_gap", gap, 0);
        repeat (5) step();

        // read frame from PHY 1F reg 2, PHY returns 1234
        run_frame(1'b1, 5'h1F, 5'h02, 16'h0000, 16'h1234, 1'b0, -1, -1);
        build(1'b1, 5'h1F, 5'h02, 16'h0000, 1'b0, exp_m, exp_en, exp_n);
        check("rd_nbits", nbits, exp_n);
        check("rd_mdo", got_m & exp_en, exp_m);
        check("rd_mdoen", got_en, exp_en);
        check("rd_done_count", ndone, 1);
        check("rd_rdata_at_done", rdata_at_done, 16'h1234);
        repeat (3) step();

        // Start pulsed at bit 20 with different fields must be ignored
        run_frame(1'b0, 5'h0A, 5'h15, 16'h0F0F, 16'h0000, 1'b0, 20, -1);
        build(1'b0, 5'h0A, 5'h15, 16'h0F0F, 1'b0, exp_m, exp_en, exp_n);
        check("inj_nbits", nbits, exp_n);
        check("inj_mdo", got_m, exp_m);
        check("inj_done_count", ndone, 1);
        check("b2b_busy_low_at_done", busy_at_done, 1'b0);

        // back-to-back read launched in the Done cycle
        run_frame(1'b1, 5'h03, 5'h11, 16'h0000, 16'hBEEF, 1'b0, -1, -1);
        build(1'b1, 5'h03, 5'h11, 16'h0000, 1'b0, exp_m, exp_en, exp_n);
        check("b2b_nbits", nbits, exp_n);
        check("b2b_mdoen", got_en, exp_en);
        check("b2b_rdata", rdata_at_done, 16'hBEEF);
        check("b2b_busy_gap", gap, 0);
        repeat (3) step();

        // reset during data bit 7 of a read
        run_frame(1'b1, 5'h07, 5'h09, 16'h0000, 16'hFFFF, 1'b0, -1, PRE + 16 + 7);
        check("abort_busy", Busy, 1'b0);
        check("abort_mdoen", MdoEn, 1'b0);
        check("abort_rdata", RData, 16'h0000);
        ndone = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (Done) ndone++;
        end
        check("abort_no_done", ndone, 0);

`ifdef ETH_MDIO_NOPRE_EN
        run_frame(1'b0, 5'h01, 5'h04, 16'hA5C3, 16'h0000, 1'b1, -1, -1);
        check("nopre_nbits", nbits, 32);
        check("nopre_first_bit", got_m[31], 1'b0);
        check("nopre_mdo", got_m[31:0], 32'h5092_A5C3);
        check("nopre_done_count", ndone, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
